// File: rtl/muldiv_pkg.sv
// Purpose : shared types and constants for the iterative multiply/divide unit.
// Latency : n/a (declarations only).
// Backpressure: n/a. Contents: op_e opcode enum, state_e FSM enum, iteration constants.
package muldiv_pkg;

    localparam int MD_ITER  = 32;
    localparam int MD_CNT_W = 5;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        MD_IDLE   = 2'd0,
        MD_RUN    = 2'd1,
        MD_FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_core.sv
// Purpose : unsigned iterative datapath; shift-add multiply or restoring divide, one bit per step.
// Latency : XLEN steps after load; results are valid while the controller holds step_i low.
// Backpressure: none; advances only when step_i is high, reloads on load_i.
// Ports: clk/rst; load_i + mag_a_i/mag_b_i load operands; is_div_i selects the algorithm;
//        step_i runs one iteration; prod_o = 2*XLEN product, quo_o/rem_o = divide results.
module muldiv_core #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              is_div_i,
    input  logic              step_i,
    input  logic [XLEN-1:0]   mag_a_i,
    input  logic [XLEN-1:0]   mag_b_i,
    output logic [2*XLEN-1:0] prod_o,
    output logic [XLEN-1:0]   quo_o,
    output logic [XLEN-1:0]   rem_o
);

    // acc_q: multiply keeps {partial product, remaining multiplier bits};
    // divide uses only the low half as the dividend-in / quotient-out shift register.
    logic [2*XLEN-1:0] acc_q, acc_d;
    // Multiplicand for multiply, divisor for divide.
    logic [XLEN-1:0]   opnd_q, opnd_d;
    // Remainder always ends below the divisor, so XLEN bits suffice between steps.
    logic [XLEN-1:0]   rem_q, rem_d;

    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;

    always_comb begin
        add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        // 33-bit partial remainder: previous remainder with next dividend bit shifted in.
        shifted = {rem_q, acc_q[XLEN-1]};
        diff    = shifted - {1'b0, opnd_q};

        acc_d  = acc_q;
        opnd_d = opnd_q;
        rem_d  = rem_q;

        if (load_i) begin
            opnd_d = is_div_i ? mag_b_i : mag_a_i;
            acc_d  = {{XLEN{1'b0}}, (is_div_i ? mag_a_i : mag_b_i)};
            rem_d  = '0;
        end else if (step_i) begin
            if (is_div_i) begin
                // Restore (keep shifted) when the trial subtraction goes negative.
                if (!diff[XLEN]) begin
                    rem_d             = diff[XLEN-1:0];
                    acc_d[XLEN-1:0]   = {acc_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d             = shifted[XLEN-1:0];
                    acc_d[XLEN-1:0]   = {acc_q[XLEN-2:0], 1'b0};
                end
            end else begin
                // Add on multiplier LSB, then shift the whole accumulator right (carry enters at top).
                acc_d = {add_sum, acc_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
            rem_q  <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            rem_q  <= rem_d;
        end
    end

    assign prod_o = acc_q;
    assign quo_o  = acc_q[XLEN-1:0];
    assign rem_o  = rem_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Purpose : MULT/MULTU/DIV/DIVU sequencer owning HI/LO; sign handling, commit and flags around muldiv_core.
// Latency : BusyE high 33 cycles from the cycle after an accepted Start; HI/LO visible as BusyE falls.
// Backpressure: StartE ignored while busy (pipeline stalls on BusyE); FlushE aborts RUN, ignored in FINISH.
// Ports: clk/rst; StartE/OpE/SrcAE/SrcBE issue; FlushE kills; BusyE, DoneM, HiOut, LoOut, DivZero status.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StartE,
    input  logic [1:0]      OpE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            FlushE,
    output logic            BusyE,
    output logic            DoneM,
    output logic [XLEN-1:0] HiOut,
    output logic [XLEN-1:0] LoOut,
    output logic            DivZero
);

    localparam int ITER  = XLEN;
    localparam int CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              divz_q, divz_d;
    logic              div_q, div_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic              bzero_q, bzero_d;

    logic              load, step;
    logic              in_sign_a, in_sign_b;
    logic [XLEN-1:0]   in_mag_a, in_mag_b;
    logic              core_is_div;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;

    // Operand decode at issue: OpE[0]==0 selects the signed variants.
    always_comb begin
        in_sign_a = ~OpE[0] & SrcAE[XLEN-1];
        in_sign_b = ~OpE[0] & SrcBE[XLEN-1];
        in_mag_a  = in_sign_a ? -SrcAE : SrcAE;
        in_mag_b  = in_sign_b ? -SrcBE : SrcBE;
    end

    // The core sees the incoming opcode on the load cycle, the latched one afterwards.
    assign core_is_div = (state_q == MD_IDLE) ? OpE[1] : div_q;

    muldiv_core #(.XLEN(XLEN)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .is_div_i (core_is_div),
        .step_i   (step),
        .mag_a_i  (in_mag_a),
        .mag_b_i  (in_mag_b),
        .prod_o   (prod),
        .quo_o    (quo),
        .rem_o    (rem)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        divz_d   = divz_q;
        div_d    = div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        bzero_d  = bzero_q;
        load     = 1'b0;
        step     = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            MD_IDLE: begin
                if (StartE && !FlushE) begin
                    load     = 1'b1;
                    state_d  = MD_RUN;
                    cnt_d    = '0;
                    div_d    = OpE[1];
                    sign_a_d = in_sign_a;
                    sign_b_d = in_sign_b;
                    bzero_d  = (SrcBE == '0);
                    divz_d   = 1'b0;
                end
            end
            MD_RUN: begin
                if (FlushE) begin
                    state_d = MD_IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = MD_FINISH;
                    end
                end
            end
            MD_FINISH: begin
                state_d = MD_IDLE;
                done_d  = 1'b1;
                if (div_q) begin
                    // With a zero divisor the restoring loop leaves |SrcA| in the
                    // remainder, so the remainder sign fix-up reproduces SrcA as issued.
                    hi_d = sign_a_q ? -rem : rem;
                    if (bzero_q) begin
                        lo_d   = '1;
                        divz_d = 1'b1;
                    end else begin
                        lo_d = (sign_a_q ^ sign_b_q) ? -quo : quo;
                    end
                end else begin
                    {hi_d, lo_d} = (sign_a_q ^ sign_b_q) ? -prod : prod;
                end
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase

        busy_d = (state_d != MD_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            divz_q   <= 1'b0;
            div_q    <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            bzero_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            divz_q   <= divz_d;
            div_q    <= div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            bzero_q  <= bzero_d;
        end
    end

    assign BusyE   = busy_q;
    assign DoneM   = done_q;
    assign HiOut   = hi_q;
    assign LoOut   = lo_q;
    assign DivZero = divz_q;

endmodule
